// File: rtl/linebuf_ring.sv
// linebuf_ring - single-clock N-line ring buffer: writer commits DE lines into slots, reader addresses by absolute line number.
module linebuf_ring #(
    parameter int LINES_LOG2 = 5,
    parameter int XW         = 11,
    parameter int CH_W       = 8,
    parameter int NUM_CH     = 3,
    parameter int DW         = NUM_CH * CH_W
) (
    input  logic          PCLK_i,
    input  logic          reset_n,
    input  logic          wr_frame_start_i,
    input  logic          wr_valid_i,
    input  logic          wr_de_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [10:0]   rd_line_i,
    input  logic [XW-1:0] rd_x_i,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_valid_o,
    output logic          rd_miss_o,
    output logic [10:0]   lines_written_o,
    output logic          wr_ovf_o
);
    localparam int          SLOTS = 1 << LINES_LOG2;
    localparam int          AW    = LINES_LOG2 + XW;
    localparam logic [XW:0] X_MAX = (XW+1)'(1) << XW;
    localparam logic [10:0] HIST  = 11'(SLOTS - 1);
    localparam logic [10:0] LW_SAT = 11'h7FF;

    typedef enum logic {IDLE, ACTIVE} wr_state_t;

    wr_state_t             state_q, state_d;
    logic [XW:0]           wr_x_q, wr_x_d;
    logic [LINES_LOG2-1:0] wr_slot_q, wr_slot_d;
    logic [10:0]           lw_q, lw_d;
    logic                  ovf_q, ovf_d;
    logic [XW:0]           width_q [SLOTS];
    logic [XW:0]           width_d [SLOTS];

    logic                  we;
    logic [AW-1:0]         waddr;

    logic [AW-1:0]         raddr_q, raddr_d;
    logic                  ok0_q, ok0_d, en0_q, en0_d;
    logic                  ok1_q, en1_q;
    logic [DW-1:0]         ram_rd_q;
    logic [DW-1:0]         mem [1 << AW];

    logic [LINES_LOG2-1:0] rd_slot;
    logic [10:0]           rd_age;

    always_comb begin
        state_d   = state_q;
        wr_x_d    = wr_x_q;
        wr_slot_d = wr_slot_q;
        lw_d      = lw_q;
        ovf_d     = ovf_q;
        width_d   = width_q;
        we        = 1'b0;
        waddr     = {wr_slot_q, wr_x_q[XW-1:0]};
        // Frame start outranks a same-cycle commit; the partial line is simply abandoned.
        if (wr_frame_start_i) begin
            state_d   = IDLE;
            wr_slot_d = '0;
            lw_d      = '0;
            ovf_d     = 1'b0;
        end else if (wr_valid_i) begin
            case (state_q)
                IDLE: begin
                    if (wr_de_i) begin
                        we      = 1'b1;
                        waddr   = {wr_slot_q, {XW{1'b0}}};
                        wr_x_d  = (XW+1)'(1);
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (wr_de_i) begin
                        if (wr_x_q != X_MAX) begin
                            we     = 1'b1;
                            wr_x_d = wr_x_q + (XW+1)'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        width_d[wr_slot_q] = wr_x_q;
                        wr_slot_d          = wr_slot_q + LINES_LOG2'(1);
                        if (lw_q != LW_SAT) begin
                            lw_d = lw_q + 11'd1;
                        end
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // The line currently being filled is lines_written_o itself, so it always fails rd_line_i < lines_written_o.
    always_comb begin
        rd_slot = rd_line_i[LINES_LOG2-1:0];
        rd_age  = lw_q - rd_line_i;
        ok0_d   = (rd_line_i < lw_q) && (rd_age <= HIST)
                  && ({1'b0, rd_x_i} < width_q[rd_slot]);
        en0_d   = rd_en_i;
        raddr_d = {rd_slot, rd_x_i};
    end

    always_ff @(posedge PCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            wr_x_q    <= '0;
            wr_slot_q <= '0;
            lw_q      <= '0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                width_q[i] <= '0;
            end
            raddr_q   <= '0;
            ok0_q     <= 1'b0;
            en0_q     <= 1'b0;
            ok1_q     <= 1'b0;
            en1_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_x_q    <= wr_x_d;
            wr_slot_q <= wr_slot_d;
            lw_q      <= lw_d;
            ovf_q     <= ovf_d;
            width_q   <= width_d;
            raddr_q   <= raddr_d;
            ok0_q     <= ok0_d;
            en0_q     <= en0_d;
            ok1_q     <= ok0_q;
            en1_q     <= en0_q;
        end
    end

    // Storage is unreset; the read returns the pre-write word on an address collision.
    always_ff @(posedge PCLK_i) begin
        if (we) begin
            mem[waddr] <= wr_data_i;
        end
        ram_rd_q <= mem[raddr_q];
    end

    assign rd_valid_o      = en1_q;
    assign rd_miss_o       = en1_q & ~ok1_q;
    assign rd_data_o       = (en1_q & ok1_q) ? ram_rd_q : '0;
    assign lines_written_o = lw_q;
    assign wr_ovf_o        = ovf_q;
endmodule
